// File: rtl/write_buffer.sv
// -----------------------------------------------------------------------------
// write_buffer
//   Posted write buffer between a cache and main memory. Dirty-line evictions
//   are queued in a small circular FIFO and drained to memory one line at a
//   time with a valid/ack handshake. Pushes to a line that is already queued
//   (and not currently being written) coalesce in place. Line-fill reads look
//   the buffer up combinationally so the cache never reads stale memory.
//
//   Ports
//     clk, rst_n              clock, synchronous active-low reset
//     write_buffer_en         push request (evicted dirty line)
//     addr_to_write_buffer    push address, bits [3:0] ignored
//     data_to_write_buffer    push line data
//     wb_full / wb_empty      occupancy flags from the registered count
//     wb_overflow             sticky: a push was dropped while full
//     read_main_memory_en     line-fill lookup request
//     addr_to_main_memory     lookup address, bits [3:0] ignored
//     fwd_hit / fwd_data      lookup result (data zero on miss)
//     wr_mem_en               memory write request (drain FSM in WRITE)
//     addr_to_mem/data_to_mem head entry presented to memory (zero when idle)
//     mem_ack                 memory accepts the presented write
// -----------------------------------------------------------------------------
module write_buffer #(
   parameter int DEPTH           = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int CACHELINE_WIDTH = 128
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       write_buffer_en,
   input  logic [ADDR_WIDTH-1:0]      addr_to_write_buffer,
   input  logic [CACHELINE_WIDTH-1:0] data_to_write_buffer,
   output logic                       wb_full,
   output logic                       wb_empty,
   output logic                       wb_overflow,
   input  logic                       read_main_memory_en,
   input  logic [ADDR_WIDTH-1:0]      addr_to_main_memory,
   output logic                       fwd_hit,
   output logic [CACHELINE_WIDTH-1:0] fwd_data,
   output logic                       wr_mem_en,
   output logic [ADDR_WIDTH-1:0]      addr_to_mem,
   output logic [CACHELINE_WIDTH-1:0] data_to_mem,
   input  logic                       mem_ack
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int LINE_W = ADDR_WIDTH - 4;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_WRITE = 1'b1
   } state_e;

   // Entry storage. Only the valid bits are reset; line/data are qualified by
   // valid everywhere they are observed.
   logic [DEPTH-1:0]           valid_q;
   logic [LINE_W-1:0]          line_q [DEPTH];
   logic [CACHELINE_WIDTH-1:0] data_q [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   state_e           state_q, state_d;

   logic [LINE_W-1:0] push_line;
   logic [LINE_W-1:0] rd_line;
   logic              coal_hit;
   logic [PTR_W-1:0]  coal_idx;
   logic              push_alloc;
   logic              push_coal;
   logic              push_drop;
   logic              pop;
   logic [PTR_W-1:0]  fwd_idx;

   // Low address bits select a byte within the line and are not used here.
   logic unused_low_bits;
   assign unused_low_bits = ^{addr_to_write_buffer[3:0], addr_to_main_memory[3:0]};

   assign push_line = addr_to_write_buffer[ADDR_WIDTH-1:4];
   assign rd_line   = addr_to_main_memory[ADDR_WIDTH-1:4];

   assign wb_full     = (count_q == CNT_W'(DEPTH));
   assign wb_empty    = (count_q == '0);
   assign wb_overflow = ovf_q;
   assign wr_mem_en   = (state_q == S_WRITE);

   // The head is frozen while it is being written to memory, so it is never a
   // coalesce target in WRITE; a push to that line becomes a fresh entry.
   always_comb begin
      coal_hit = 1'b0;
      coal_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (line_q[i] == push_line) &&
             !((state_q == S_WRITE) && (PTR_W'(i) == head_q))) begin
            coal_hit = 1'b1;
            coal_idx = PTR_W'(i);
         end
      end
   end

   // Fullness is judged on the registered count: a pop on the same edge does
   // not make room for the push.
   assign push_coal  = write_buffer_en && coal_hit;
   assign push_alloc = write_buffer_en && !coal_hit && !wb_full;
   assign push_drop  = write_buffer_en && !coal_hit && wb_full;
   assign pop        = (state_q == S_WRITE) && mem_ack;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
      if (push_alloc) begin
         tail_d = tail_q + PTR_W'(1);
      end
      case ({push_alloc, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (push_drop) begin
         ovf_d = 1'b1;
      end
   end

   // Drain FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (mem_ack) begin
               state_d = (count_q > CNT_W'(1)) ? S_WRITE : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         state_q <= S_IDLE;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else begin
         if (pop) begin
            valid_q[head_q] <= 1'b0;
         end
         if (push_alloc) begin
            valid_q[tail_q] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_alloc) begin
         line_q[tail_q] <= push_line;
         data_q[tail_q] <= data_to_write_buffer;
      end else if (push_coal) begin
         data_q[coal_idx] <= data_to_write_buffer;
      end
   end

   // Memory side: head entry, zero while idle.
   always_comb begin
      addr_to_mem = '0;
      data_to_mem = '0;
      if (state_q == S_WRITE) begin
         addr_to_mem = {line_q[head_q], 4'b0000};
         data_to_mem = data_q[head_q];
      end
   end

   // Forwarding: walk oldest to youngest so the youngest match wins. The head
   // being popped this cycle is still valid and still forwards.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = head_q;
      if (read_main_memory_en) begin
         for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PTR_W'(k);
            if (valid_q[fwd_idx] && (line_q[fwd_idx] == rd_line)) begin
               fwd_hit  = 1'b1;
               fwd_data = data_q[fwd_idx];
            end
         end
      end
   end

endmodule
